// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU. One division in flight;
// W+1 cycles start-to-done for a non-zero divisor, 2 cycles for a zero divisor.
module div_unit #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_divsigned,
    input  logic [W-1:0] i_dividend,
    input  logic [W-1:0] i_divisor,
    input  logic         i_divstart,
    input  logic         i_annul,
    output logic [W-1:0] o_quotient,
    output logic [W-1:0] o_remainder,
    output logic         o_done,
    output logic         o_ready
);

    localparam int CW = $clog2(W + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_DIVZERO = 2'd1;
    localparam logic [1:0] S_RUN     = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    // Two's complement negate when requested; wraps modulo 2^W.
    function automatic logic [W-1:0] cond_negate(input logic neg, input logic [W-1:0] v);
        if (neg) begin
            cond_negate = (~v) + {{(W-1){1'b0}}, 1'b1};
        end else begin
            cond_negate = v;
        end
    endfunction

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  p_q, p_d;
    logic [W-1:0]  q_q, q_d;
    logic [W-1:0]  dvsr_q, dvsr_d;
    logic          dnd_neg_q, dnd_neg_d;
    logic          dvs_neg_q, dvs_neg_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [W-1:0]  rem_q, rem_d;

    // Partial remainder is kept W bits wide: it is always below the divisor,
    // so the (W+1)-th bit of P is provably zero and only the shifted trial needs it.
    logic [W:0]    shifted_s;
    logic [W:0]    trial_s;
    logic          borrow_s;
    logic [W-1:0]  p_step_s;
    logic [W-1:0]  q_step_s;

    assign shifted_s = {p_q, q_q[W-1]};
    assign trial_s   = shifted_s - {1'b0, dvsr_q};
    assign borrow_s  = trial_s[W];
    assign p_step_s  = borrow_s ? shifted_s[W-1:0] : trial_s[W-1:0];
    assign q_step_s  = {q_q[W-2:0], ~borrow_s};

    // Next-state and datapath control for the divide FSM.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        p_d       = p_q;
        q_d       = q_q;
        dvsr_d    = dvsr_q;
        dnd_neg_d = dnd_neg_q;
        dvs_neg_d = dvs_neg_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        case (state_q)
            S_IDLE: begin
                if (i_divstart && !i_annul) begin
                    dnd_neg_d = i_divsigned & i_dividend[W-1];
                    dvs_neg_d = i_divsigned & i_divisor[W-1];
                    dvsr_d    = cond_negate(i_divsigned & i_divisor[W-1], i_divisor);
                    q_d       = cond_negate(i_divsigned & i_dividend[W-1], i_dividend);
                    p_d       = '0;
                    cnt_d     = '0;
                    if (i_divisor == '0) begin
                        state_d = S_DIVZERO;
                    end else begin
                        state_d = S_RUN;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DIVZERO: begin
                if (i_annul) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                    quo_d   = '0;
                    rem_d   = '0;
                end
            end
            S_RUN: begin
                if (i_annul) begin
                    state_d = S_IDLE;
                end else begin
                    p_d   = p_step_s;
                    q_d   = q_step_s;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(W - 1)) begin
                        // Quotient sign follows operand-sign mismatch; remainder follows the dividend.
                        state_d = S_DONE;
                        quo_d   = cond_negate(dnd_neg_q ^ dvs_neg_q, q_step_s);
                        rem_d   = cond_negate(dnd_neg_q, p_step_s);
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            p_q       <= '0;
            q_q       <= '0;
            dvsr_q    <= '0;
            dnd_neg_q <= 1'b0;
            dvs_neg_q <= 1'b0;
            quo_q     <= '0;
            rem_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            p_q       <= p_d;
            q_q       <= q_d;
            dvsr_q    <= dvsr_d;
            dnd_neg_q <= dnd_neg_d;
            dvs_neg_q <= dvs_neg_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
        end
    end

    assign o_quotient  = quo_q;
    assign o_remainder = rem_q;
    assign o_done      = (state_q == S_DONE);
    assign o_ready     = (state_q == S_IDLE);

endmodule
